imem_fetch_responder: RTL

//  Multi-cycle instruction-memory responder on the fetch side of the pipelined RV32I core.
//  - Accepts one word fetch request at a time from the PC stage.
//  - Returns the instruction word after a fixed LATENCY.
//  - Drives `stall`; the PC stage consumes it as its hold input while a fetch is outstanding.
//  - Provides a program-load write port for the bench and boot.

---
 rtl/imem_fetch_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: one outstanding word fetch, fixed latency,
// with a program-load write port that is only honoured while idle.
module imem_fetch_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        o_req_ready,
    input  logic        i_flush,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_inst,
    output logic        o_resp_err,
    output logic        o_stall,
    input  logic        i_load_we,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data
);

    localparam int          IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH_32 = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_resp_valid;
    logic [31:0] r_resp_inst;
    logic        r_resp_err;
    logic [31:0] r_mem [MEM_DEPTH];

    logic             w_accept;
    logic             w_load_ok;
    logic [IDX_W-1:0] w_load_idx;
    logic [31:0]      w_rd_addr;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_bad;
    logic             w_fwd;
    logic [31:0]      w_rd_data;

    assign o_req_ready = ~reset & ((r_state == S_IDLE) | (r_state == S_RESP)) & ~i_flush;
    assign w_accept    = i_req_valid & o_req_ready;

    assign w_load_ok  = i_load_we & ~reset & (r_state == S_IDLE)
                      & (i_load_addr[1:0] == 2'b00)
                      & ({2'b00, i_load_addr[31:2]} < DEPTH_32);
    assign w_load_idx = i_load_addr[IDX_W+1:2];

    // In WAIT the read uses the latched address; otherwise the read can only
    // happen on an accept with single-cycle latency, so the live request is used.
    assign w_rd_addr = (r_state == S_WAIT) ? r_addr : i_req_addr;
    assign w_rd_idx  = w_rd_addr[IDX_W+1:2];
    assign w_rd_bad  = (w_rd_addr[1:0] != 2'b00) | ({2'b00, w_rd_addr[31:2]} >= DEPTH_32);

    // A same-edge load to the word being read must win, so it is bypassed.
    assign w_fwd     = w_load_ok & (w_load_idx == w_rd_idx);
    assign w_rd_data = w_fwd ? i_load_data : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[w_load_idx] <= i_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_inst  <= NOP;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_inst  <= NOP;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_addr <= i_req_addr;
                        if (LATENCY == 1) begin
                            r_state      <= S_RESP;
                            r_cnt        <= 4'd0;
                            r_resp_valid <= 1'b1;
                            r_resp_inst  <= w_rd_bad ? NOP : w_rd_data;
                            r_resp_err   <= w_rd_bad;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
                S_WAIT: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state      <= S_RESP;
                        r_cnt        <= 4'd0;
                        r_resp_valid <= 1'b1;
                        r_resp_inst  <= w_rd_bad ? NOP : w_rd_data;
                        r_resp_err   <= w_rd_bad;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_inst  = r_resp_inst;
    assign o_resp_err   = r_resp_err;
    assign o_stall      = ~reset & ((r_state == S_WAIT) | (i_req_valid & ~r_resp_valid));

endmodule
